baccarat_dealer_fsm: RTL and testbench
======================================

Name: baccarat_dealer_fsm

Overview:
- Controller that sequences one baccarat hand through the card/score datapath: card registers, dealcard source and two scorehand instances (player, banker).
- Issues one-hot card-load strobes in dealing order and applies the third-card rules using the live hand totals.
- Drives the win lights and holds the result until a new game is requested.

Parameters:
- None. Card encoding is fixed: 1..13, where 1 = ace and 10..13 score 0; 0 = no card.

Ports:
- slow_clock  input  1  sole clock; all state changes on its rising edge
- reset  input  1  synchronous, active-high reset
- new_game  input  1  request to start the next hand; honoured only in DONE
- pscore  input  4  player hand total from the player scorehand (0..9)
- dscore  input  4  banker hand total from the banker scorehand (0..9)
- pcard3  input  4  player third-card register contents (raw card code)
- load_pcard1, load_pcard2, load_pcard3  output  1 each  player card-register load strobes
- load_dcard1, load_dcard2, load_dcard3  output  1 each  banker card-register load strobes
- clear_cards  output  1  clears all six card registers in the datapath
- player_win_light  output  1  player-win indicator (registered)
- dealer_win_light  output  1  banker-win indicator (registered)
- done  output  1  hand complete, result valid

Behaviour:
- States: P1, D1, P2, D2, EVAL, P3, BDEC, D3, RESULT, DONE, CLR. The state register resets to P1.
- Load outputs and clear_cards are Moore-decoded from state, with at most one load strobe high per cycle.
  - P1 -> load_pcard1, D1 -> load_dcard1, P2 -> load_pcard2, D2 -> load_dcard2, P3 -> load_pcard3, D3 -> load_dcard3, CLR -> clear_cards.
  - While reset is high, all load strobes are 0, clear_cards is 1 and done is 0.
- Datapath latency: a card loaded on edge N is reflected in pscore/dscore/pcard3 during cycle N+1. Decision states read the inputs only after that latency has elapsed.
- Unconditional transitions: P1 -> D1 -> P2 -> D2 -> EVAL.
- EVAL:
  - pscore >= 8 or dscore >= 8 (natural) -> RESULT.
  - else pscore <= 5 -> P3.
  - else (player 6/7 stands) and dscore <= 5 -> D3.
  - else -> RESULT.
- P3 -> BDEC.
- BDEC: convert pcard3 to a third-card value v, where v = pcard3 if 1..9, otherwise 0 (covers 0, 10..15). Banker draws (-> D3) when:
  - dscore 0..2: always
  - dscore 3: v != 8
  - dscore 4: v in 2..7
  - dscore 5: v in 4..7
  - dscore 6: v in 6..7
  - dscore 7: never
  - If the banker does not draw -> RESULT.
- D3 -> RESULT.
- RESULT: on exit edge, player_win_light <= (pscore > dscore) | tie; dealer_win_light <= (dscore > pscore) | tie, where tie = (pscore == dscore), so a tie lights both. Next state is DONE.
- DONE:
  - done = 1; lights held.
  - new_game = 0 -> stay in DONE.
  - new_game = 1 -> CLR.
  - new_game in any other state is ignored.
- CLR: clear_cards = 1 for one cycle; both lights cleared on exit edge; next state is P1.
- Reset values: state P1, player_win_light = 0, dealer_win_light = 0, done = 0.
- Reset mid-hand: the next state is P1 and the lights clear. The datapath is cleared by the same reset.
- Hand length in cycles after reset deasserts, with done first high in the listed cycle:
  - natural or both stand: 6 cycles (done in cycle 6)
  - banker-only draw: 7 (done in cycle 7)
  - player draws, banker stands: 8 (done in cycle 8)
  - both draw: 9 (done in cycle 9)
- Score inputs outside 0..9: undefined behaviour, not checked.

Test Plan:
- Natural: after the 4 loads, pscore=8, dscore=3 -> no load_pcard3/dcard3 ever; cycle 6: done=1, player=1, dealer=0.
- Player draws, banker 3 with v=8: pscore=4, dscore=3, pcard3=8 -> load_pcard3 in cycle 5, no load_dcard3; result follows the final scores. With final pscore=2, dscore=3 -> dealer=1 only, done in cycle 8.
- Face third card: pscore=5, dscore=4, pcard3=12 (v=0) -> no banker draw. Same with pcard3=5 -> load_dcard3 in cycle 7, done in cycle 9.
- Player stands, banker draws: pscore=7, dscore=5 -> load_dcard3 in cycle 5, never load_pcard3. Final dscore=7 -> tie, both lights=1.
- Restart: in DONE, hold new_game=0 for 5 cycles -> lights stable. Pulse new_game -> clear_cards for exactly 1 cycle, lights=0, load_pcard1 the next cycle.
- Reset mid-hand: assert reset during P3 -> next cycle is P1 with load_pcard1=1; no load_dcard3 is issued; lights and done are 0.

Source files
------------

// File: rtl/baccarat_dealer_fsm.sv
`default_nettype none
// ============================================================================
// Module      : baccarat_dealer_fsm
// Description : Sequences one baccarat hand. It issues the card-load strobes in
//               dealing order, applies the third-card rules and latches the
//               win lights until a new game is requested.
// Revision    : 1.0 - initial release
// ============================================================================
module baccarat_dealer_fsm (
    input  logic       slow_clock,
    input  logic       reset,
    input  logic       new_game,
    input  logic [3:0] pscore,
    input  logic [3:0] dscore,
    input  logic [3:0] pcard3,
    output logic       load_pcard1,
    output logic       load_pcard2,
    output logic       load_pcard3,
    output logic       load_dcard1,
    output logic       load_dcard2,
    output logic       load_dcard3,
    output logic       clear_cards,
    output logic       player_win_light,
    output logic       dealer_win_light,
    output logic       done
);

    localparam logic [3:0] S_P1     = 4'd0;
    localparam logic [3:0] S_D1     = 4'd1;
    localparam logic [3:0] S_P2     = 4'd2;
    localparam logic [3:0] S_D2     = 4'd3;
    localparam logic [3:0] S_EVAL   = 4'd4;
    localparam logic [3:0] S_P3     = 4'd5;
    localparam logic [3:0] S_BDEC   = 4'd6;
    localparam logic [3:0] S_D3     = 4'd7;
    localparam logic [3:0] S_RESULT = 4'd8;
    localparam logic [3:0] S_DONE   = 4'd9;
    localparam logic [3:0] S_CLR    = 4'd10;

    logic [3:0] state_q, state_d;
    logic       pwin_q, pwin_d;
    logic       dwin_q, dwin_d;
    logic [3:0] w_third_val;
    logic       w_natural;
    logic       w_banker_draws;
    logic       w_tie;

    // Face cards and empty/out-of-range codes all count as zero.
    assign w_third_val = ((pcard3 >= 4'd1) && (pcard3 <= 4'd9)) ? pcard3 : 4'd0;
    assign w_natural   = (pscore >= 4'd8) || (dscore >= 4'd8);
    assign w_tie       = (pscore == dscore);

    always_comb begin
        w_banker_draws = 1'b0;
        case (dscore)
            4'd0, 4'd1, 4'd2: w_banker_draws = 1'b1;
            4'd3:             w_banker_draws = (w_third_val != 4'd8);
            4'd4:             w_banker_draws = (w_third_val >= 4'd2) && (w_third_val <= 4'd7);
            4'd5:             w_banker_draws = (w_third_val >= 4'd4) && (w_third_val <= 4'd7);
            4'd6:             w_banker_draws = (w_third_val >= 4'd6) && (w_third_val <= 4'd7);
            default:          w_banker_draws = 1'b0;
        endcase
    end

    always_ff @(posedge slow_clock) begin
        if (reset) begin
            state_q <= S_P1;
            pwin_q  <= 1'b0;
            dwin_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pwin_q  <= pwin_d;
            dwin_q  <= dwin_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pwin_d  = pwin_q;
        dwin_d  = dwin_q;
        case (state_q)
            S_P1:   state_d = S_D1;
            S_D1:   state_d = S_P2;
            S_P2:   state_d = S_D2;
            S_D2:   state_d = S_EVAL;
            S_EVAL: begin
                if (w_natural)
                    state_d = S_RESULT;
                else if (pscore <= 4'd5)
                    state_d = S_P3;
                else if (dscore <= 4'd5)
                    state_d = S_D3;
                else
                    state_d = S_RESULT;
            end
            S_P3:   state_d = S_BDEC;
            S_BDEC: state_d = w_banker_draws ? S_D3 : S_RESULT;
            S_D3:   state_d = S_RESULT;
            S_RESULT: begin
                pwin_d  = (pscore > dscore) | w_tie;
                dwin_d  = (dscore > pscore) | w_tie;
                state_d = S_DONE;
            end
            S_DONE: state_d = new_game ? S_CLR : S_DONE;
            S_CLR: begin
                pwin_d  = 1'b0;
                dwin_d  = 1'b0;
                state_d = S_P1;
            end
            default: state_d = S_P1;
        endcase
    end

    // Reset overrides the state decode so the datapath is held clear.
    always_comb begin
        load_pcard1 = 1'b0;
        load_pcard2 = 1'b0;
        load_pcard3 = 1'b0;
        load_dcard1 = 1'b0;
        load_dcard2 = 1'b0;
        load_dcard3 = 1'b0;
        clear_cards = 1'b0;
        done        = 1'b0;
        if (reset) begin
            clear_cards = 1'b1;
        end else begin
            case (state_q)
                S_P1:    load_pcard1 = 1'b1;
                S_D1:    load_dcard1 = 1'b1;
                S_P2:    load_pcard2 = 1'b1;
                S_D2:    load_dcard2 = 1'b1;
                S_P3:    load_pcard3 = 1'b1;
                S_D3:    load_dcard3 = 1'b1;
                S_DONE:  done        = 1'b1;
                S_CLR:   clear_cards = 1'b1;
                default: ;
            endcase
        end
    end

    assign player_win_light = pwin_q;
    assign dealer_win_light = dwin_q;

endmodule
`default_nettype wire

// File: tb/tb_baccarat_dealer_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_baccarat_dealer_fsm
// Description : Bench for the dealer controller with a card/score datapath
//               model and a rule-level baccarat reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_baccarat_dealer_fsm;

    logic       slow_clock = 1'b0;
    logic       reset;
    logic       new_game;
    logic [3:0] pscore, dscore, pcard3;
    logic       load_pcard1, load_pcard2, load_pcard3;
    logic       load_dcard1, load_dcard2, load_dcard3;
    logic       clear_cards, player_win_light, dealer_win_light, done;

    int n_vec = 0;
    int n_err = 0;

    logic [3:0] deck [6];
    logic [3:0] pc1, pc2, pc3, dc1, dc2, dc3;
    logic       exp_pl, exp_dl;
    logic [6:0] strb;

    baccarat_dealer_fsm dut (
        .slow_clock       (slow_clock),
        .reset            (reset),
        .new_game         (new_game),
        .pscore           (pscore),
        .dscore           (dscore),
        .pcard3           (pcard3),
        .load_pcard1      (load_pcard1),
        .load_pcard2      (load_pcard2),
        .load_pcard3      (load_pcard3),
        .load_dcard1      (load_dcard1),
        .load_dcard2      (load_dcard2),
        .load_dcard3      (load_dcard3),
        .clear_cards      (clear_cards),
        .player_win_light (player_win_light),
        .dealer_win_light (dealer_win_light),
        .done             (done)
    );

    always #5 slow_clock = ~slow_clock;

    function automatic int cv(input logic [3:0] c);
        return (c >= 4'd1 && c <= 4'd9) ? int'(c) : 0;
    endfunction

    // Datapath model: card registers plus scorehands.
    always @(posedge slow_clock) begin
        if (clear_cards) begin
            pc1 <= 4'd0; pc2 <= 4'd0; pc3 <= 4'd0;
            dc1 <= 4'd0; dc2 <= 4'd0; dc3 <= 4'd0;
        end else begin
            if (load_pcard1) pc1 <= deck[0];
            if (load_pcard2) pc2 <= deck[1];
            if (load_pcard3) pc3 <= deck[2];
            if (load_dcard1) dc1 <= deck[3];
            if (load_dcard2) dc2 <= deck[4];
            if (load_dcard3) dc3 <= deck[5];
        end
    end

    assign pscore = 4'((cv(pc1) + cv(pc2) + cv(pc3)) % 10);
    assign dscore = 4'((cv(dc1) + cv(dc2) + cv(dc3)) % 10);
    assign pcard3 = pc3;
    assign strb   = {clear_cards, load_dcard3, load_dcard2, load_dcard1,
                     load_pcard3, load_pcard2, load_pcard1};

    task automatic set_deck(input int p1, input int p2, input int p3,
                            input int d1, input int d2, input int d3);
        deck[0] = 4'(p1); deck[1] = 4'(p2); deck[2] = 4'(p3);
        deck[3] = 4'(d1); deck[4] = 4'(d2); deck[5] = 4'(d3);
    endtask

    // Called at the sampling point of the first P1 cycle of a hand.
    task automatic play(input string tag, input bit rand_ng, input int abort_at);
        int p, b, v, pf, bf, len;
        bit pdraw, bdraw;
        logic [6:0] exq [$];
        p = (cv(deck[0]) + cv(deck[1])) % 10;
        b = (cv(deck[3]) + cv(deck[4])) % 10;
        v = cv(deck[2]);
        pdraw = 1'b0;
        bdraw = 1'b0;
        if (!(p >= 8 || b >= 8)) begin
            if (p <= 5) begin
                pdraw = 1'b1;
                case (b)
                    0, 1, 2: bdraw = 1'b1;
                    3:       bdraw = (v != 8);
                    4:       bdraw = (v >= 2 && v <= 7);
                    5:       bdraw = (v >= 4 && v <= 7);
                    6:       bdraw = (v >= 6 && v <= 7);
                    default: bdraw = 1'b0;
                endcase
            end else begin
                bdraw = (b <= 5);
            end
        end
        pf = (p + (pdraw ? v : 0)) % 10;
        bf = (b + (bdraw ? cv(deck[5]) : 0)) % 10;
        exp_pl = (pf >= bf);
        exp_dl = (bf >= pf);
        exq.push_back(7'h01); exq.push_back(7'h08);
        exq.push_back(7'h02); exq.push_back(7'h10);
        exq.push_back(7'h00);
        if (pdraw) begin exq.push_back(7'h04); exq.push_back(7'h00); end
        if (bdraw) exq.push_back(7'h20);
        exq.push_back(7'h00);
        len = exq.size();
        for (int k = 0; k <= len; k++) begin
            n_vec++;
            if (k < len) begin
                if (strb !== exq[k] || done !== 1'b0 ||
                    player_win_light !== 1'b0 || dealer_win_light !== 1'b0) begin
                    n_err++;
                    $display("FAIL %s cycle %0d: strobes=%b done=%b lights=%b%b, required strobes=%b done=0 lights=00",
                             tag, k, strb, done, player_win_light, dealer_win_light, exq[k]);
                end
                if (k == abort_at) return;
                new_game = rand_ng ? 1'($urandom_range(0, 1)) : 1'b0;
                @(negedge slow_clock);
            end else begin
                if (strb !== 7'h00 || done !== 1'b1 ||
                    player_win_light !== exp_pl || dealer_win_light !== exp_dl) begin
                    n_err++;
                    $display("FAIL %s done cycle %0d: strobes=%b done=%b lights=%b%b, required strobes=0000000 done=1 lights=%b%b",
                             tag, k, strb, done, player_win_light, dealer_win_light, exp_pl, exp_dl);
                end
                new_game = 1'b0;
            end
        end
    endtask

    task automatic test_reset;
        reset    = 1'b1;
        new_game = 1'b0;
        repeat (3) @(posedge slow_clock);
        @(negedge slow_clock);
        n_vec++;
        if (strb !== 7'h40 || done !== 1'b0 ||
            player_win_light !== 1'b0 || dealer_win_light !== 1'b0) begin
            n_err++;
            $display("FAIL reset: strobes=%b done=%b lights=%b%b, required strobes=1000000 done=0 lights=00",
                     strb, done, player_win_light, dealer_win_light);
        end
    endtask

    task automatic release_reset;
        @(posedge slow_clock);
        #1 reset = 1'b0;
        @(negedge slow_clock);
    endtask

    task automatic test_hold;
        for (int i = 0; i < 5; i++) begin
            @(negedge slow_clock);
            n_vec++;
            if (strb !== 7'h00 || done !== 1'b1 ||
                player_win_light !== exp_pl || dealer_win_light !== exp_dl) begin
                n_err++;
                $display("FAIL hold %0d: strobes=%b done=%b lights=%b%b, required strobes=0000000 done=1 lights=%b%b",
                         i, strb, done, player_win_light, dealer_win_light, exp_pl, exp_dl);
            end
        end
    endtask

    // Called from the sampling point of a DONE cycle; ends at the next P1 cycle.
    task automatic restart;
        new_game = 1'b1;
        @(negedge slow_clock);
        new_game = 1'b0;
        n_vec++;
        if (strb !== 7'h40 || done !== 1'b0 ||
            player_win_light !== exp_pl || dealer_win_light !== exp_dl) begin
            n_err++;
            $display("FAIL clr: strobes=%b done=%b lights=%b%b, required strobes=1000000 done=0 lights=%b%b",
                     strb, done, player_win_light, dealer_win_light, exp_pl, exp_dl);
        end
        @(negedge slow_clock);
    endtask

    task automatic test_directed;
        set_deck(1, 3, 8, 1, 2, 5);   restart(); play("p_draws_b3_v8", 1'b0, -1);
        set_deck(2, 3, 12, 1, 3, 6);  restart(); play("face_third", 1'b0, -1);
        set_deck(2, 3, 5, 1, 3, 6);   restart(); play("both_draw", 1'b0, -1);
        set_deck(3, 4, 9, 2, 3, 2);   restart(); play("banker_only", 1'b0, -1);
    endtask

    task automatic test_reset_midhand;
        set_deck(1, 1, 4, 1, 1, 3);
        restart();
        play("midhand_pre", 1'b0, 5);
        reset = 1'b1;
        #1;
        n_vec++;
        if (strb !== 7'h40 || done !== 1'b0) begin
            n_err++;
            $display("FAIL midhand_reset: strobes=%b done=%b, required strobes=1000000 done=0",
                     strb, done);
        end
        set_deck(4, 4, 1, 6, 1, 2);
        release_reset();
        play("after_reset", 1'b0, -1);
    endtask

    task automatic test_random;
        for (int h = 0; h < 40; h++) begin
            for (int i = 0; i < 6; i++) deck[i] = 4'($urandom_range(1, 13));
            restart();
            play("random", 1'b1, -1);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish, required finish");
        $fatal(1, "timeout");
    end

    initial begin
        set_deck(3, 5, 7, 1, 2, 4);
        test_reset();
        release_reset();
        play("natural", 1'b0, -1);
        test_hold();
        test_directed();
        test_reset_midhand();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
